bus_mem_responder: RTL and testbench
====================================

// Module: bus_mem_responder
// PURPOSE
// - Memory-side responder for the CPU bus: services opcode/operand fetches and data reads/writes
//   issued by the control FSM, returning read data on data_in with programmable wait states.
// - Sits between the CPU core (address/rw/data_out in, data_in/rdy out) and a word RAM plus a
//   read-only vector window; the bench preloads programs through the load port.
// PARAMETERS
// - MEM_WORDS    4096      RAM depth in bytes, power of two; RAM address = address mod MEM_WORDS
// - WAIT_STATES  1         extra stall cycles per access, 0..15
// - RESET_VEC    16'h0200  value returned for reads of 16'hFFFC (low) / 16'hFFFD (high)
// - IRQ_VEC      16'h0300  value returned for reads of 16'hFFFE (low) / 16'hFFFF (high)
// PORTS
// - ph2       in   1   single bus clock, all state updates on rising edge
// - reset     in   1   asynchronous, active-low reset
// - bus_req   in   1   CPU requests a bus cycle; held with address/rw/data_out until rdy seen high
// - address   in   16  byte address
// - rw        in   1   1 = read, 0 = write
// - data_out  in   8   CPU write data
// - data_in   out  8   read data to CPU, valid in the cycle rdy rises for a read
// - rdy       out  1   1 = not stalling / access complete; 0 = CPU must hold
// - load_en   in   1   bench preload strobe (write RAM directly)
// - load_addr in   16  preload address (mod MEM_WORDS)
// - load_data in   8   preload byte
// - wr_err    out  1   sticky: a CPU write targeted 16'hFFFA..16'hFFFF
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, rdy=1, data_in=8'h00, wr_err=0, wait counter=0; RAM
//   contents are NOT cleared. Reset mid-access aborts it; a pending write is never committed.
// - FSM states IDLE, WAIT, DONE.
//   - IDLE: if load_en -> write RAM[load_addr mod MEM_WORDS]=load_data, stay IDLE (load wins over
//     bus_req; CPU keeps bus_req held). Else if bus_req -> capture address/rw/data_out, rdy<=0,
//     cnt<=WAIT_STATES, go WAIT. Else stay IDLE, rdy=1.
//   - WAIT: if cnt==0 -> go DONE, else cnt<=cnt-1. rdy stays 0. load_en ignored.
//   - DONE: perform access with captured values: read -> data_in<=byte; write -> commit RAM (or set
//     wr_err if in 16'hFFFA..FFFF, RAM unchanged). rdy<=1 for this cycle. Next: if bus_req
//     and the captured request has been consumed this cycle, return to IDLE (back-to-back requests
//     are re-captured from IDLE the following cycle).
// - Latency: request captured at edge N; rdy=1 with valid data after edge N+WAIT_STATES+2.
//   Throughput: one access per WAIT_STATES+3 cycles.
// - Address decode: 16'hFFFA/FFFB read 8'h00; 16'hFFFC..FFFF read vector params (little endian);
//   all other addresses alias into RAM modulo MEM_WORDS (wrap-around, no error).
// - data_in holds its last read value through writes, IDLE and WAIT (only changes in DONE-read).
// - Inputs sampled only at capture; changes of address/rw/data_out during WAIT/DONE are ignored.
// - bus_req dropped during WAIT: access still completes (no cancel).
// - wr_err clears only on reset.
// TESTING
// - Reset release, WAIT_STATES=1: load 8'hA9 at 16'h0200, read 16'h0200 -> rdy low 3 cycles,
//   then rdy=1 with data_in=8'hA9.
// - Read 16'hFFFC then 16'hFFFD -> data_in 8'h00 then 8'h02; write 8'h55 to 16'hFFFE -> wr_err=1,
//   subsequent read 16'hFFFE still 8'h00.
// - Wrap: write 8'h3C to 16'h1005 (MEM_WORDS=4096) -> read 16'h0005 returns 8'h3C.
// - load_en and bus_req same IDLE cycle -> load committed first, bus access captured next cycle;
//   read of the loaded address returns new value.
// - Write 8'h77 to 16'h0010, assert reset during WAIT -> rdy=1, data_in=00 immediately; read
//   16'h0010 afterwards returns prior preload value, not 8'h77.
// - WAIT_STATES=0 and 15: 4 back-to-back reads -> rdy-high spacing exactly 3 and 18 cycles.

Source files
------------

// File: rtl/bus_mem_responder_if.sv
// CPU-side bus bundle between the core (or bench) and the memory responder.
interface bus_mem_responder_if;
   logic        bus_req;
   logic [15:0] address;
   logic        rw;
   logic [7:0]  data_out;
   logic [7:0]  data_in;
   logic        rdy;
   logic        load_en;
   logic [15:0] load_addr;
   logic [7:0]  load_data;
   logic        wr_err;

   // CPU / preload driver side
   modport master (
      output bus_req, address, rw, data_out, load_en, load_addr, load_data,
      input  data_in, rdy, wr_err
   );

   // Memory responder side
   modport slave (
      input  bus_req, address, rw, data_out, load_en, load_addr, load_data,
      output data_in, rdy, wr_err
   );
endinterface

// File: rtl/bus_mem_responder.sv
// Memory-side bus responder: byte RAM plus read-only vector window, with
// programmable wait states between request capture and completion.
module bus_mem_responder #(
   parameter int unsigned MEM_WORDS   = 4096,
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [15:0] RESET_VEC   = 16'h0200,
   parameter logic [15:0] IRQ_VEC     = 16'h0300
) (
   input  logic                 ph2,
   input  logic                 reset,
   bus_mem_responder_if.slave   bus
);

   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [15:0] addr;
      logic        rw;
      logic [7:0]  wdata;
   } req_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   req_t            req_q, req_d;
   logic            rdy_q, rdy_d;
   logic [7:0]      data_in_q, data_in_d;
   logic            wr_err_q, wr_err_d;

   logic            ram_we_c;
   logic [AW-1:0]   ram_waddr_c;
   logic [7:0]      ram_wdata_c;
   logic [7:0]      rd_byte_c;
   logic            vec_hit_c;

   logic [7:0]      mem [MEM_WORDS];

   // Upper preload address bits are discarded by the modulo mapping.
   logic            unused_load_addr;
   assign unused_load_addr = ^bus.load_addr;

   assign bus.rdy     = rdy_q;
   assign bus.data_in = data_in_q;
   assign bus.wr_err  = wr_err_q;

   // Read decode of the captured address: vector window overrides RAM.
   always_comb begin
      rd_byte_c = mem[req_q.addr[AW-1:0]];
      vec_hit_c = (req_q.addr >= 16'hFFFA);
      case (req_q.addr)
         16'hFFFA, 16'hFFFB: rd_byte_c = 8'h00;
         16'hFFFC:           rd_byte_c = RESET_VEC[7:0];
         16'hFFFD:           rd_byte_c = RESET_VEC[15:8];
         16'hFFFE:           rd_byte_c = IRQ_VEC[7:0];
         16'hFFFF:           rd_byte_c = IRQ_VEC[15:8];
         default:            ;
      endcase
   end

   // Next-state, capture, stall and RAM write-port control.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      rdy_d       = rdy_q;
      data_in_d   = data_in_q;
      wr_err_d    = wr_err_q;
      ram_we_c    = 1'b0;
      ram_waddr_c = req_q.addr[AW-1:0];
      ram_wdata_c = req_q.wdata;

      case (state_q)
         ST_IDLE: begin
            rdy_d = 1'b1;
            if (bus.load_en) begin
               ram_we_c    = 1'b1;
               ram_waddr_c = bus.load_addr[AW-1:0];
               ram_wdata_c = bus.load_data;
            end else if (bus.bus_req) begin
               req_d.addr  = bus.address;
               req_d.rw    = bus.rw;
               req_d.wdata = bus.data_out;
               rdy_d       = 1'b0;
               cnt_d       = CW'(WAIT_STATES);
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_DONE: begin
            rdy_d   = 1'b1;
            state_d = ST_IDLE;
            if (req_q.rw) begin
               data_in_d = rd_byte_c;
            end else if (vec_hit_c) begin
               wr_err_d = 1'b1;
            end else begin
               ram_we_c = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset aborts any in-flight access.
   always_ff @(posedge ph2 or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         req_q     <= '0;
         rdy_q     <= 1'b1;
         data_in_q <= 8'h00;
         wr_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         rdy_q     <= rdy_d;
         data_in_q <= data_in_d;
         wr_err_q  <= wr_err_d;
      end
   end

   // Byte RAM write port; contents survive reset.
   always_ff @(posedge ph2) begin
      if (ram_we_c) begin
         mem[ram_waddr_c] <= ram_wdata_c;
      end
   end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: latency, decode, wrap, load priority,
// reset abort and back-to-back spacing at 0 and 15 wait states.
module tb_bus_mem_responder;

   logic ph2 = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   always #5 ph2 = ~ph2;

   // Free-running cycle index used to time rdy rises.
   always @(posedge ph2) cyc <= cyc + 1;

   bus_mem_responder_if b1 ();
   bus_mem_responder_if b0 ();
   bus_mem_responder_if b15 ();

   bus_mem_responder #(.MEM_WORDS(4096), .WAIT_STATES(1)) u_dut (
      .ph2   (ph2),
      .reset (rst_n),
      .bus   (b1)
   );

   bus_mem_responder #(.MEM_WORDS(4096), .WAIT_STATES(0)) u_dut_ws0 (
      .ph2   (ph2),
      .reset (rst_n),
      .bus   (b0)
   );

   bus_mem_responder #(.MEM_WORDS(4096), .WAIT_STATES(15)) u_dut_ws15 (
      .ph2   (ph2),
      .reset (rst_n),
      .bus   (b15)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge ph2);
         #1;
      end
   endtask

   task automatic do_load(input logic [15:0] addr, input logic [7:0] data);
      b1.load_en   = 1'b1;
      b1.load_addr = addr;
      b1.load_data = data;
      tick(1);
      b1.load_en   = 1'b0;
   endtask

   // One bus access on the WAIT_STATES=1 instance; scrambles inputs after capture.
   task automatic access(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                         output int lows, output logic [7:0] rd);
      b1.bus_req  = 1'b1;
      b1.rw       = rw;
      b1.address  = addr;
      b1.data_out = wd;
      tick(1);
      b1.address  = ~addr;
      b1.rw       = ~rw;
      b1.data_out = ~wd;
      lows = 0;
      while (b1.rdy !== 1'b1 && lows < 40) begin
         lows++;
         tick(1);
      end
      rd         = b1.data_in;
      b1.bus_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lows;
      logic [7:0]  rd;
      int          n0, n15;
      int          t0 [4];
      int          t15 [4];
      logic        prev0, prev15;

      b1.bus_req = 0;  b1.address = 0;  b1.rw = 0;  b1.data_out = 0;
      b1.load_en = 0;  b1.load_addr = 0; b1.load_data = 0;
      b0.bus_req = 0;  b0.address = 0;  b0.rw = 0;  b0.data_out = 0;
      b0.load_en = 0;  b0.load_addr = 0; b0.load_data = 0;
      b15.bus_req = 0; b15.address = 0; b15.rw = 0; b15.data_out = 0;
      b15.load_en = 0; b15.load_addr = 0; b15.load_data = 0;

      rst_n = 1'b0;
      tick(3);
      chk("reset_rdy",     16'(b1.rdy),     16'h1);
      chk("reset_data_in", 16'(b1.data_in), 16'h00);
      chk("reset_wr_err",  16'(b1.wr_err),  16'h0);
      rst_n = 1'b1;
      tick(1);

      // Preloaded read with one wait state.
      do_load(16'h0200, 8'hA9);
      access(1'b1, 16'h0200, 8'h00, lows, rd);
      chk("read_0200_lat",  16'(lows), 16'd3);
      chk("read_0200_data", 16'(rd),   16'h00A9);

      // Reset vector window.
      access(1'b1, 16'hFFFC, 8'h00, lows, rd);
      chk("read_fffc_lat",  16'(lows), 16'd3);
      chk("read_fffc_data", 16'(rd),   16'h0000);
      access(1'b1, 16'hFFFD, 8'h00, lows, rd);
      chk("read_fffd_data", 16'(rd),   16'h0002);

      // Write into the vector window flags an error and leaves data_in alone.
      access(1'b0, 16'hFFFE, 8'h55, lows, rd);
      chk("write_fffe_lat",    16'(lows),       16'd3);
      chk("write_fffe_wr_err", 16'(b1.wr_err),  16'h1);
      chk("write_hold_data",   16'(rd),         16'h0002);
      access(1'b1, 16'hFFFE, 8'h00, lows, rd);
      chk("read_fffe_data", 16'(rd), 16'h0000);
      access(1'b1, 16'hFFFF, 8'h00, lows, rd);
      chk("read_ffff_data", 16'(rd), 16'h0003);

      // Address wrap modulo MEM_WORDS.
      access(1'b0, 16'h1005, 8'h3C, lows, rd);
      access(1'b1, 16'h0005, 8'h00, lows, rd);
      chk("wrap_read_0005", 16'(rd),        16'h003C);
      chk("wr_err_sticky",  16'(b1.wr_err), 16'h1);

      // Load and request in the same idle cycle: load first, capture next.
      b1.load_en   = 1'b1;
      b1.load_addr = 16'h0040;
      b1.load_data = 8'h5A;
      b1.bus_req   = 1'b1;
      b1.rw        = 1'b1;
      b1.address   = 16'h0040;
      tick(1);
      chk("load_wins_rdy", 16'(b1.rdy), 16'h1);
      b1.load_en = 1'b0;
      access(1'b1, 16'h0040, 8'h00, lows, rd);
      chk("load_then_read_lat",  16'(lows), 16'd3);
      chk("load_then_read_data", 16'(rd),   16'h005A);

      // Reset during WAIT aborts a pending write.
      do_load(16'h0010, 8'h11);
      access(1'b1, 16'h0200, 8'h00, lows, rd);
      chk("pre_abort_data", 16'(rd), 16'h00A9);
      b1.bus_req  = 1'b1;
      b1.rw       = 1'b0;
      b1.address  = 16'h0010;
      b1.data_out = 8'h77;
      tick(1);
      chk("abort_in_wait_rdy", 16'(b1.rdy), 16'h0);
      rst_n = 1'b0;
      #1;
      chk("abort_rdy",     16'(b1.rdy),     16'h1);
      chk("abort_data_in", 16'(b1.data_in), 16'h00);
      chk("abort_wr_err",  16'(b1.wr_err),  16'h0);
      b1.bus_req = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      access(1'b1, 16'h0010, 8'h00, lows, rd);
      chk("abort_no_commit", 16'(rd), 16'h0011);

      // Back-to-back reads at 0 and 15 wait states, bus_req held throughout.
      b0.bus_req  = 1'b1; b0.rw  = 1'b1; b0.address  = 16'hFFFD;
      b15.bus_req = 1'b1; b15.rw = 1'b1; b15.address = 16'hFFFD;
      n0 = 0; n15 = 0;
      for (int i = 0; i < 4; i++) begin
         t0[i]  = 0;
         t15[i] = 0;
      end
      prev0  = b0.rdy;
      prev15 = b15.rdy;
      for (int c = 0; c < 120; c++) begin
         tick(1);
         if (b0.rdy && !prev0 && n0 < 4) begin
            t0[n0] = cyc;
            n0++;
         end
         if (b15.rdy && !prev15 && n15 < 4) begin
            t15[n15] = cyc;
            n15++;
         end
         prev0  = b0.rdy;
         prev15 = b15.rdy;
      end
      b0.bus_req  = 1'b0;
      b15.bus_req = 1'b0;
      chk("ws0_rise_count",  16'(n0),  16'd4);
      chk("ws15_rise_count", 16'(n15), 16'd4);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("ws0_spacing_%0d", i),  16'(t0[i+1] - t0[i]),   16'd3);
         chk($sformatf("ws15_spacing_%0d", i), 16'(t15[i+1] - t15[i]), 16'd18);
      end
      chk("ws0_data",  16'(b0.data_in),  16'h0002);
      chk("ws15_data", 16'(b15.data_in), 16'h0002);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
